// File: rtl/opb_register_simulink2ppc.sv
// OPB slave exposing a fabric-captured data word to the PPC, with a 3-state ack FSM.
// Define OPB_SIMULINK2PPC_STATUS_EN to add the offset-1 status register (new flag + overrun count).
module opb_register_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h00000000,
  parameter logic [31:0] C_HIGHADDR   = 32'h000000FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  input  logic [C_OPB_DWIDTH-1:0]   user_data_in,
  input  logic                      user_data_valid,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup
);

  localparam logic [C_OPB_AWIDTH-1:0] ADDR_MASK = C_OPB_AWIDTH'(~(C_HIGHADDR - C_BASEADDR));
  localparam logic [C_OPB_AWIDTH-1:0] ADDR_BASE = C_OPB_AWIDTH'(C_BASEADDR);
  localparam bit unused_family = (C_FAMILY == "");

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

  state_t                    state_q, state_d;
  logic                      rst_block_q, rst_block_d;
  logic [C_OPB_DWIDTH-1:0]   hold_q, hold_d;
  logic                      new_flag_q, new_flag_d;
  logic [C_OPB_DWIDTH-1:0]   rd_data;
  logic                      hit, ack, rd_en, clr_read;
  logic [1:0]                offset;

  logic unused_inputs;
  assign unused_inputs = ^{OPB_BE, OPB_seqAddr, OPB_DBus, unused_family};

  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign offset = OPB_ABus[C_OPB_AWIDTH-4 +: 2];
  assign hit    = OPB_select && ((OPB_ABus & ADDR_MASK) == ADDR_BASE);

  // Ack is withheld if the master drops select before the ACK cycle completes.
  assign ack      = (state_q == S_ACK) && OPB_select;
  assign rd_en    = ack && OPB_RNW;
  assign clr_read = rd_en && (offset == 2'd0);

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q     <= S_IDLE;
      rst_block_q <= 1'b1;
      hold_q      <= '0;
      new_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_block_q <= rst_block_d;
      hold_q      <= hold_d;
      new_flag_q  <= new_flag_d;
    end
  end

  // A select still high from before reset must drop before a new transfer is accepted.
  assign rst_block_d = rst_block_q && OPB_select;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (hit && !rst_block_q) state_d = S_ACK;
      S_ACK:  state_d = OPB_select ? S_WAIT : S_IDLE;
      S_WAIT: if (!OPB_select) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hold_d     = hold_q;
    new_flag_d = new_flag_q;
    if (user_data_valid) begin
      hold_d     = user_data_in;
      new_flag_d = 1'b1;
    end else if (clr_read) begin
      new_flag_d = 1'b0;
    end
  end

`ifdef OPB_SIMULINK2PPC_STATUS_EN
  logic [15:0] ovr_cnt_q, ovr_cnt_d;
  logic        ovr_inc, ovr_clr;

  assign ovr_inc = user_data_valid && new_flag_q && !clr_read;
  assign ovr_clr = ack && !OPB_RNW && (offset == 2'd1);

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (ovr_clr)
      ovr_cnt_d = '0;
    else if (ovr_inc && (ovr_cnt_q != 16'hFFFF))
      ovr_cnt_d = ovr_cnt_q + 16'd1;
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) ovr_cnt_q <= '0;
    else         ovr_cnt_q <= ovr_cnt_d;
  end

  always_comb begin
    rd_data = '0;
    unique case (offset)
      2'd0: rd_data = hold_q;
      2'd1: begin
        rd_data[C_OPB_DWIDTH-1] = new_flag_q;
        rd_data[15:0]           = ovr_cnt_q;
      end
      default: rd_data = '0;
    endcase
  end
`else
  always_comb begin
    rd_data = '0;
    if (offset == 2'd0) rd_data = hold_q;
  end
`endif

  // Wired-OR bus: drive only during a read ack.
  assign Sl_xferAck = ack;
  assign Sl_DBus    = rd_en ? rd_data : '0;

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Directed bench for opb_register_simulink2ppc: vector table plus hand-written corner sequences.
module tb_opb_register_simulink2ppc;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus_w;
  logic        rnw, sel, seq;
  logic [31:0] udata;
  logic        uvalid;
  logic [0:31] sl_dbus;
  logic        sl_ack, sl_err, sl_retry, sl_tout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  opb_register_simulink2ppc dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus_w),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
    .user_data_in(udata), .user_data_valid(uvalid),
    .Sl_DBus(sl_dbus), .Sl_xferAck(sl_ack), .Sl_errAck(sl_err),
    .Sl_retry(sl_retry), .Sl_toutSup(sl_tout)
  );

  typedef struct {
    logic [31:0] addr;
    bit          rnw;
    bit          pulse;
    logic [31:0] pdata;
    bit          exp_ack;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [31:0] d);
    @(posedge clk); #1;
    uvalid = 1'b1; udata = d;
    @(posedge clk); #1;
    uvalid = 1'b0;
  endtask

  // Hit cycle, ACK cycle, following cycle; optional valid strobe during the ACK cycle.
  task automatic xfer(input logic [31:0] addr, input bit r, input logic [31:0] wd,
                      input bit cv, input logic [31:0] cd,
                      output bit a0, output bit a1, output bit a2,
                      output logic [31:0] d0, output logic [31:0] d1, output logic [31:0] d2);
    @(posedge clk); #1;
    sel = 1'b1; abus = addr; rnw = r; dbus_w = wd;
    @(negedge clk); a0 = sl_ack; d0 = sl_dbus;
    @(posedge clk); #1;
    if (cv) begin uvalid = 1'b1; udata = cd; end
    @(negedge clk); a1 = sl_ack; d1 = sl_dbus;
    @(posedge clk); #1;
    sel = 1'b0; uvalid = 1'b0;
    @(negedge clk); a2 = sl_ack; d2 = sl_dbus;
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    bit a0, a1, a2;
    logic [31:0] d0, d1, d2;
    xfer(addr, 1'b1, 32'h0, 1'b0, 32'h0, a0, a1, a2, d0, d1, d2);
    chk({name, "_ack"}, {31'b0, a1}, 32'd1);
    chk({name, "_data"}, d1, exp);
  endtask

  initial begin
    bit a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [31:0] exp_s1, exp_s2;

    vt[0] = '{32'h00, 1'b1, 1'b0, 32'h0,        1'b1, 32'h00000000};
    vt[1] = '{32'h00, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    vt[2] = '{32'h08, 1'b1, 1'b0, 32'h0,        1'b1, 32'h00000000};
    vt[3] = '{32'h0C, 1'b1, 1'b0, 32'h0,        1'b1, 32'h00000000};
    vt[4] = '{32'h04, 1'b1, 1'b0, 32'h0,        1'b1, 32'h00000000};
    vt[5] = '{32'h00, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00000000};
    vt[6] = '{32'h00, 1'b1, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF};
    vt[7] = '{32'h103, 1'b1, 1'b0, 32'h0,       1'b0, 32'h00000000};
    vt[8] = '{32'hFC, 1'b1, 1'b1, 32'hA5A50001, 1'b1, 32'h00000000};
    vt[9] = '{32'h00, 1'b1, 1'b0, 32'h0,        1'b1, 32'hA5A50001};

    rst = 1'b1; abus = '0; be = 4'hF; dbus_w = '0; rnw = 1'b1; sel = 1'b0; seq = 1'b0;
    udata = '0; uvalid = 1'b0;
    #3;
    chk("rst_ack", {31'b0, sl_ack}, 32'd0);
    chk("rst_dbus", sl_dbus, 32'd0);
    chk("rst_err", {29'b0, sl_err, sl_retry, sl_tout}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      if (vt[i].pulse) pulse(vt[i].pdata);
      xfer(vt[i].addr, vt[i].rnw, 32'h12345678, 1'b0, 32'h0, a0, a1, a2, d0, d1, d2);
      chk($sformatf("v%0d_ack_pre", i), {31'b0, a0}, 32'd0);
      chk($sformatf("v%0d_dbus_pre", i), d0, 32'd0);
      chk($sformatf("v%0d_ack", i), {31'b0, a1}, {31'b0, vt[i].exp_ack});
      chk($sformatf("v%0d_data", i), d1, vt[i].exp_data);
      chk($sformatf("v%0d_ack_post", i), {31'b0, a2}, 32'd0);
      chk($sformatf("v%0d_dbus_post", i), d2, 32'd0);
    end

    // Capture coincident with the clearing read: old value returned, flag stays set.
    pulse(32'h00000011);
    xfer(32'h00, 1'b1, 32'h0, 1'b1, 32'h00000055, a0, a1, a2, d0, d1, d2);
    chk("coinc_ack", {31'b0, a1}, 32'd1);
    chk("coinc_data", d1, 32'h00000011);
`ifdef OPB_SIMULINK2PPC_STATUS_EN
    rd_chk("coinc_flag", 32'h04, 32'h80000000);
`endif
    rd_chk("coinc_next", 32'h00, 32'h00000055);

    // Select dropped before the ACK cycle: no ack, no data.
    @(posedge clk); #1;
    sel = 1'b1; abus = 32'h00; rnw = 1'b1;
    @(posedge clk); #1;
    sel = 1'b0;
    @(negedge clk);
    chk("abort_ack", {31'b0, sl_ack}, 32'd0);
    chk("abort_dbus", sl_dbus, 32'd0);
    @(negedge clk);
    chk("abort_ack2", {31'b0, sl_ack}, 32'd0);
    rd_chk("after_abort", 32'h00, 32'h00000055);

    // Reset during WAIT with select held: no ack until select drops and re-hits.
    @(posedge clk); #1;
    sel = 1'b1; abus = 32'h00; rnw = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("wrst_ack", {31'b0, sl_ack}, 32'd0);
    chk("wrst_dbus", sl_dbus, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("wrst_hold_ack%0d", k), {31'b0, sl_ack}, 32'd0);
    end
    @(posedge clk); #1;
    sel = 1'b0;
    @(posedge clk); #1;
    rd_chk("post_rst_read", 32'h00, 32'h00000000);

    // Status register (reads zero when not built in).
`ifdef OPB_SIMULINK2PPC_STATUS_EN
    exp_s1 = 32'h80000002; exp_s2 = 32'h00000002;
`else
    exp_s1 = 32'h00000000; exp_s2 = 32'h00000000;
`endif
    pulse(32'h1); pulse(32'h2); pulse(32'h3);
    rd_chk("stat_ovr", 32'h04, exp_s1);
    rd_chk("stat_rd0", 32'h00, 32'h00000003);
    rd_chk("stat_clr_flag", 32'h04, exp_s2);
    xfer(32'h04, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0, a0, a1, a2, d0, d1, d2);
    chk("stat_wr_ack", {31'b0, a1}, 32'd1);
    rd_chk("stat_cnt_clr", 32'h04, 32'h00000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/opb_register_simulink2ppc.md
OPB_REGISTER_SIMULINK2PPC -- requirements
Module: opb_register_simulink2ppc

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h00000000, base of the slave address window.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h000000FF, top of the window; window size is a power of two.
REQ-003 SHALL have parameter C_OPB_AWIDTH, default 32, OPB address width.
REQ-004 SHALL have parameter C_OPB_DWIDTH, default 32, OPB data width.
REQ-005 SHALL have parameter C_FAMILY, default "virtex5", target family string (no functional effect).
REQ-006 SHALL have one clock, OPB_Clk, and an asynchronous active-high reset, OPB_Rst; all state is clocked on rising OPB_Clk.
REQ-007 SHALL have ports:
- OPB_Clk  in  1  bus and user clock
- OPB_Rst  in  1  async active-high reset
- OPB_ABus  in  [0:31]  address
- OPB_BE  in  [0:3]  byte enables (ignored)
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1=read, 0=write
- OPB_select  in  1  transfer active
- OPB_seqAddr  in  1  sequential burst hint (ignored)
- user_data_in  in  [31:0]  word from fabric logic
- user_data_valid  in  1  capture strobe
- Sl_DBus  out  [0:31]  read data
- Sl_xferAck  out  1  transfer acknowledge
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  constant 0

Function
REQ-010 SHALL decode a hit when OPB_select=1 and OPB_ABus lies in [C_BASEADDR, C_HIGHADDR]; offset = OPB_ABus[28:29] word index.
REQ-011 SHALL implement FSM IDLE -> ACK -> WAIT -> IDLE: IDLE->ACK on hit; ACK lasts exactly one cycle; WAIT holds until OPB_select=0.
REQ-012 SHALL assert Sl_xferAck only in ACK, i.e. one cycle, on the cycle after the hit is first sampled (latency 1).
REQ-013 SHALL drive Sl_DBus only in ACK with RNW=1, and all-zero otherwise (wired-OR bus).
REQ-014 SHALL capture user_data_in into hold register and set new_flag on every cycle with user_data_valid=1.
REQ-015 SHALL return hold register on reads at offset 0, mapped Sl_DBus[0:31] = hold[31:0] (bit 0 = MSB).
REQ-016 SHALL clear new_flag in the ACK cycle of an offset-0 read; if user_data_valid=1 in that same cycle, the set wins and Sl_DBus returns the pre-capture value.
REQ-017 SHALL acknowledge writes at any offset with no effect, except per REQ-031.
REQ-018 SHALL return zero for reads at offsets 2 and 3.
REQ-019 SHALL abandon an in-progress transfer and return to IDLE without ack if OPB_select falls in ACK's preceding cycle (no stale ack).

Reset
REQ-020 SHALL on OPB_Rst=1, immediately and asynchronously: FSM=IDLE, Sl_xferAck=0, Sl_DBus=0, hold=0, new_flag=0, overrun count=0.
REQ-021 SHALL, after reset deasserts mid-transfer, wait for a fresh hit in IDLE before acking.

Configuration
REQ-030 SHALL compile the status register in when macro OPB_SIMULINK2PPC_STATUS_EN is defined.
REQ-031 With the macro: offset 1 read returns Sl_DBus[0]=new_flag, Sl_DBus[16:31]=16-bit overrun count, others 0; overrun count increments (saturating at 0xFFFF) on user_data_valid while new_flag=1 and no clearing read in that cycle; any write to offset 1 clears the count (simultaneous increment lost).
REQ-032 Without the macro: offset 1 reads zero, no overrun counter logic exists, new_flag still governs REQ-016 internally.

Verification
REQ-040 Reset, then read offset 0 -> Sl_xferAck one cycle after select, Sl_DBus=0x00000000.
REQ-041 Pulse valid with user_data_in=0xDEADBEEF, read offset 0 -> Sl_DBus=0xDEADBEEF; Sl_DBus=0 outside the ack cycle.
REQ-042 (STATUS_EN) Pulse valid three times without reading, read offset 1 -> Sl_DBus[0]=1, count=2; read offset 0 then offset 1 -> new_flag=0, count=2; write offset 1 -> count=0.
REQ-043 Valid with 0x00000055 coincident with offset-0 read ack holding 0x00000011 -> returns 0x00000011, new_flag remains 1, next read returns 0x00000055.
REQ-044 Access to C_HIGHADDR+4 -> no ack, Sl_DBus=0; write to offset 0 -> acked, hold unchanged.
REQ-045 Assert OPB_Rst during WAIT with select held high -> no further ack until select drops and re-asserts with a hit.
